// File: rtl/ysyx_23060221_bus_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owner ids, default bus widths.
package ysyx_23060221_bus_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Owner id doubles as the grant-vector bit index (bit0 = IFU, bit1 = LSU).
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060221_rr_pick.sv
// Two-way request picker: single requester wins; on a tie either LSU (fixed) or the one not granted last.
module ysyx_23060221_rr_pick
    import ysyx_23060221_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed_pri,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (fixed_pri || (last == OWN_IFU)) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_23060221_mem_arb.sv
// Shares one memory port between IFU and LSU, one transaction at a time, with a response watchdog.
//  state | meaning
//  IDLE  | waiting for a requester; grant is combinational on req_valid
//  ISSUE | registered payload presented on mem_req_*
//  WAIT  | waiting for mem response; watchdog running
//  RESP  | response held for the owner until it takes it
module ysyx_23060221_mem_arb
    import ysyx_23060221_bus_pkg::*;
#(
    parameter int AW       = BUS_AW,
    parameter int DW       = BUS_DW,
    parameter int PRIORITY = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_addr,
    output logic            ifu_resp_valid,
    input  logic            ifu_resp_ready,
    output logic [DW-1:0]   ifu_rdata,
    output logic            ifu_resp_err,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [AW-1:0]   lsu_addr,
    input  logic            lsu_wen,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_wmask,
    output logic            lsu_resp_valid,
    input  logic            lsu_resp_ready,
    output logic [DW-1:0]   lsu_rdata,
    output logic            lsu_resp_err,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_wen,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_resp_valid,
    output logic            mem_resp_ready,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_resp_err
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] WD_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]      state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wen_q, wen_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW/8-1:0] wmask_q, wmask_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [TW-1:0]   wdog_q, wdog_d;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       owner_resp_ready;

    assign req = {lsu_req_valid, ifu_req_valid} & {2{state_q == ST_IDLE}};

    ysyx_23060221_rr_pick u_pick (
        .req       (req),
        .last      (last_q),
        .fixed_pri (PRIORITY != 0),
        .gnt       (gnt)
    );

    assign owner_resp_ready = (owner_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wdog_d  = wdog_q;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    owner_d = gnt[1];
                    last_d  = gnt[1];
                    state_d = ST_ISSUE;
                    if (gnt[1]) begin
                        addr_d  = lsu_addr;
                        wen_d   = lsu_wen;
                        wdata_d = lsu_wdata;
                        wmask_d = lsu_wmask;
                    end else begin
                        addr_d  = ifu_addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                    wdog_d  = '0;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    rdata_d = wen_q ? '0 : mem_rdata;
                    err_d   = mem_resp_err;
                    state_d = ST_RESP;
                end else if ((TIMEOUT != 0) && (wdog_q == WD_LAST)) begin
                    // Memory never answered: synthesise an error response.
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wdog_d = wdog_q + TW'(1);
                end
            end
            ST_RESP: begin
                if (owner_resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IFU;
            last_q  <= OWN_LSU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
        end
    end

    // Grant is the only combinational requester output; it must drop while reset is held.
    assign ifu_req_ready  = gnt[0] & rst_n;
    assign lsu_req_ready  = gnt[1] & rst_n;

    assign mem_req_valid  = (state_q == ST_ISSUE);
    assign mem_resp_ready = (state_q == ST_WAIT);
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;

    assign ifu_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_IFU);
    assign lsu_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_LSU);
    assign ifu_rdata      = rdata_q;
    assign lsu_rdata      = rdata_q;
    assign ifu_resp_err   = err_q & (owner_q == OWN_IFU);
    assign lsu_resp_err   = err_q & (owner_q == OWN_LSU);

endmodule

// File: tb/tb_ysyx_23060221_mem_arb.sv
// Bench for the IFU/LSU memory arbiter: instance 0 round-robin, instance 1 LSU-priority, both TIMEOUT=8.
module tb_ysyx_23060221_mem_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [1:0]  ifu_req_valid, lsu_req_valid, ifu_resp_ready, lsu_resp_ready;
    logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
    logic        lsu_wen, mem_resp_err;
    logic [3:0]  lsu_wmask;
    logic [1:0]  mem_req_ready, mem_resp_valid;

    wire [1:0] ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid;
    wire [1:0] ifu_resp_err, lsu_resp_err, mem_req_valid, mem_wen, mem_resp_ready;
    wire [1:0][31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
    wire [1:0][3:0]  mem_wmask;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        ysyx_23060221_mem_arb #(.AW(32), .DW(32), .PRIORITY(k), .TIMEOUT(8)) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .ifu_req_valid  (ifu_req_valid[k]),
            .ifu_req_ready  (ifu_req_ready[k]),
            .ifu_addr       (ifu_addr),
            .ifu_resp_valid (ifu_resp_valid[k]),
            .ifu_resp_ready (ifu_resp_ready[k]),
            .ifu_rdata      (ifu_rdata[k]),
            .ifu_resp_err   (ifu_resp_err[k]),
            .lsu_req_valid  (lsu_req_valid[k]),
            .lsu_req_ready  (lsu_req_ready[k]),
            .lsu_addr       (lsu_addr),
            .lsu_wen        (lsu_wen),
            .lsu_wdata      (lsu_wdata),
            .lsu_wmask      (lsu_wmask),
            .lsu_resp_valid (lsu_resp_valid[k]),
            .lsu_resp_ready (lsu_resp_ready[k]),
            .lsu_rdata      (lsu_rdata[k]),
            .lsu_resp_err   (lsu_resp_err[k]),
            .mem_req_valid  (mem_req_valid[k]),
            .mem_req_ready  (mem_req_ready[k]),
            .mem_addr       (mem_addr[k]),
            .mem_wen        (mem_wen[k]),
            .mem_wdata      (mem_wdata[k]),
            .mem_wmask      (mem_wmask[k]),
            .mem_resp_valid (mem_resp_valid[k]),
            .mem_resp_ready (mem_resp_ready[k]),
            .mem_rdata      (mem_rdata),
            .mem_resp_err   (mem_resp_err)
        );
    end

    // Memory model: accepts after req_delay stalled cycles, answers the next cycle unless silent.
    int   req_delay;
    bit   silent, flush;
    logic [1:0]      pend;
    logic [1:0][7:0] mwait;

    always_comb begin
        mem_req_ready  = '0;
        mem_resp_valid = '0;
        for (int k = 0; k < 2; k++) begin
            mem_req_ready[k]  = mem_req_valid[k] && (32'(mwait[k]) >= req_delay);
            mem_resp_valid[k] = pend[k] && !silent;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= '0;
            mwait <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (mem_req_valid[k] && mem_req_ready[k]) begin
                    pend[k]  <= 1'b1;
                    mwait[k] <= '0;
                end else if (mem_req_valid[k]) begin
                    mwait[k] <= mwait[k] + 8'd1;
                end
                if ((mem_resp_valid[k] && mem_resp_ready[k]) || flush) pend[k] <= 1'b0;
            end
        end
    end

    typedef struct {int inst; logic [31:0] addr; logic wen; logic [31:0] wdata; logic [3:0] wmask;} pay_t;
    typedef struct {int inst; logic owner; logic [31:0] rdata; logic err;} resp_t;
    typedef struct {int inst; bit ifu_v; bit lsu_v; bit exp_lsu; bit err;} vec_t;

    pay_t  pay_q[$];
    resp_t resp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no event expected event within bound", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int k, input bit lsu, input logic [31:0] a, input bit w,
                            input logic [31:0] wd, input logic [3:0] wm, input logic [31:0] rd, input bit er);
        pay_t  p;
        resp_t r;
        p = '{inst: k, addr: a, wen: lsu ? w : 1'b0, wdata: lsu ? wd : 32'h0, wmask: lsu ? wm : 4'h0};
        r = '{inst: k, owner: lsu, rdata: (lsu && w) ? 32'h0 : rd, err: er};
        pay_q.push_back(p);
        resp_q.push_back(r);
    endtask

    task automatic resp_pop(input int k, input logic own, input logic [31:0] rd, input logic er);
        resp_t r;
        if (resp_q.size() == 0) begin
            fail("resp_unexpected");
        end else begin
            r = resp_q.pop_front();
            chk("resp_inst", 64'(k), 64'(r.inst));
            chk("resp_owner", own, r.owner);
            chk("resp_rdata", rd, r.rdata);
            chk("resp_err", er, r.err);
        end
    endtask

    always @(negedge clk) begin : mon
        pay_t p;
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (mem_req_valid[k] && mem_req_ready[k]) begin
                    if (pay_q.size() == 0) begin
                        fail("pay_unexpected");
                    end else begin
                        p = pay_q.pop_front();
                        chk("pay_inst", 64'(k), 64'(p.inst));
                        chk("pay_addr", mem_addr[k], p.addr);
                        chk("pay_wen", mem_wen[k], p.wen);
                        chk("pay_wdata", mem_wdata[k], p.wdata);
                        chk("pay_wmask", mem_wmask[k], p.wmask);
                    end
                end
                if (ifu_resp_valid[k] && ifu_resp_ready[k]) resp_pop(k, 1'b0, ifu_rdata[k], ifu_resp_err[k]);
                if (lsu_resp_valid[k] && lsu_resp_ready[k]) resp_pop(k, 1'b1, lsu_rdata[k], lsu_resp_err[k]);
            end
        end
    end

    task automatic wait_resp(input int k);
        for (int i = 0; i < 60; i++) begin
            if ((ifu_resp_valid[k] && ifu_resp_ready[k]) || (lsu_resp_valid[k] && lsu_resp_ready[k])) begin
                tick(1);
                return;
            end
            tick(1);
        end
        fail("resp_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

    vec_t vecs[12];
    int   wcnt;
    bit   seen;

    initial begin
        vecs[0]  = '{0, 1, 1, 0, 0};
        vecs[1]  = '{0, 1, 1, 1, 0};
        vecs[2]  = '{0, 1, 1, 0, 0};
        vecs[3]  = '{0, 1, 1, 1, 0};
        vecs[4]  = '{0, 1, 0, 0, 1};
        vecs[5]  = '{0, 0, 1, 1, 1};
        vecs[6]  = '{1, 1, 1, 1, 0};
        vecs[7]  = '{1, 1, 1, 1, 0};
        vecs[8]  = '{1, 1, 1, 1, 0};
        vecs[9]  = '{1, 1, 1, 1, 0};
        vecs[10] = '{1, 1, 0, 0, 0};
        vecs[11] = '{1, 1, 1, 1, 0};

        rst_n = 1'b0;
        ifu_req_valid = 2'b11; lsu_req_valid = 2'b11;
        ifu_resp_ready = 2'b11; lsu_resp_ready = 2'b11;
        ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_wen = 1'b0; lsu_wmask = '0;
        mem_rdata = '0; mem_resp_err = 1'b0;
        req_delay = 0; silent = 1'b0; flush = 1'b0;
        #1;
        chk("rst_ifu_req_ready", ifu_req_ready, 2'b00);
        chk("rst_lsu_req_ready", lsu_req_ready, 2'b00);
        chk("rst_mem_req_valid", mem_req_valid, 2'b00);
        chk("rst_mem_resp_ready", mem_resp_ready, 2'b00);
        chk("rst_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 4'h0);
        chk("rst_mem_addr", mem_addr, 64'h0);
        tick(2);
        ifu_req_valid = 2'b00; lsu_req_valid = 2'b00;
        rst_n = 1'b1;
        tick(1);

        // Arbitration table: ties, single requesters, error routing.
        for (int i = 0; i < 12; i++) begin
            mem_rdata    = 32'hA000_0000 + 32'(i);
            mem_resp_err = vecs[i].err;
            ifu_addr     = 32'h8000_0000 + 32'(i * 4);
            lsu_addr     = 32'h8000_2000 + 32'(i * 4);
            lsu_wen      = 1'b0;
            push_exp(vecs[i].inst, vecs[i].exp_lsu, vecs[i].exp_lsu ? lsu_addr : ifu_addr,
                     1'b0, 32'h0, 4'h0, mem_rdata, vecs[i].err);
            ifu_req_valid[vecs[i].inst] = vecs[i].ifu_v;
            lsu_req_valid[vecs[i].inst] = vecs[i].lsu_v;
            #1;
            chk($sformatf("arb%0d_ifu_ready", i), ifu_req_ready[vecs[i].inst], vecs[i].ifu_v & ~vecs[i].exp_lsu);
            chk($sformatf("arb%0d_lsu_ready", i), lsu_req_ready[vecs[i].inst], vecs[i].exp_lsu);
            tick(1);
            ifu_req_valid = 2'b00; lsu_req_valid = 2'b00;
            wait_resp(vecs[i].inst);
        end
        mem_resp_err = 1'b0;

        // Single IFU read, zero-wait memory: cycle-accurate latency.
        mem_rdata = 32'h0000_0413;
        ifu_addr  = 32'h8000_0000;
        push_exp(0, 1'b0, ifu_addr, 1'b0, 32'h0, 4'h0, mem_rdata, 1'b0);
        ifu_req_valid[0] = 1'b1;
        #1;
        chk("t1_grant", ifu_req_ready[0], 1'b1);
        chk("t1_lsu_no_grant", lsu_req_ready[0], 1'b0);
        tick(1);
        ifu_req_valid = 2'b00;
        chk("t1_c1_mem_req_valid", mem_req_valid[0], 1'b1);
        tick(1);
        chk("t1_c2_mem_resp_ready", mem_resp_ready[0], 1'b1);
        chk("t1_c2_resp_valid", ifu_resp_valid[0], 1'b0);
        tick(1);
        chk("t1_c3_ifu_resp_valid", ifu_resp_valid[0], 1'b1);
        chk("t1_c3_lsu_resp_valid", lsu_resp_valid[0], 1'b0);
        chk("t1_c3_rdata", ifu_rdata[0], 32'h0000_0413);
        chk("t1_c3_err", ifu_resp_err[0], 1'b0);
        wait_resp(0);

        // LSU write with a 5-cycle stalled request: payload must stay registered.
        req_delay = 5;
        mem_rdata = 32'hFFFF_FFFF;
        lsu_addr = 32'h8000_1000; lsu_wen = 1'b1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
        push_exp(0, 1'b1, lsu_addr, 1'b1, lsu_wdata, lsu_wmask, mem_rdata, 1'b0);
        lsu_req_valid[0] = 1'b1;
        #1;
        chk("t3_grant", lsu_req_ready[0], 1'b1);
        tick(1);
        lsu_req_valid = 2'b00;
        lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t3_stall%0d_valid", c), mem_req_valid[0], 1'b1);
            chk($sformatf("t3_stall%0d_payload", c),
                {mem_addr[0], mem_wen[0], mem_wdata[0][30:0]}, {32'h8000_1000, 1'b1, 31'h5EAD_BEEF});
            chk($sformatf("t3_stall%0d_wmask", c), mem_wmask[0], 4'b0011);
            tick(1);
        end
        req_delay = 0;
        wait_resp(0);

        // Watchdog: silent memory, IFU read times out after 8 WAIT cycles.
        silent = 1'b1;
        ifu_resp_ready[0] = 1'b0;
        ifu_addr = 32'h8000_0040;
        push_exp(0, 1'b0, ifu_addr, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        ifu_req_valid[0] = 1'b1;
        tick(1);
        ifu_req_valid = 2'b00;
        wcnt = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (ifu_resp_valid[0]) seen = 1'b1;
            else begin
                if (mem_resp_ready[0]) wcnt++;
                tick(1);
            end
        end
        if (!seen) fail("t4_timeout_resp");
        chk("t4_wait_cycles", 64'(wcnt), 64'd8);
        chk("t4_err", ifu_resp_err[0], 1'b1);
        chk("t4_rdata", ifu_rdata[0], 32'h0);
        silent = 1'b0;
        mem_rdata = 32'h1234_5678;
        tick(2);
        chk("t4_late_not_taken", mem_resp_ready[0], 1'b0);
        chk("t4_late_rdata", ifu_rdata[0], 32'h0);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        ifu_resp_ready[0] = 1'b1;
        wait_resp(0);
        mem_rdata = 32'h0BAD_F00D;
        lsu_addr = 32'h8000_3000; lsu_wen = 1'b0;
        push_exp(0, 1'b1, lsu_addr, 1'b0, 32'h0, 4'h0, mem_rdata, 1'b0);
        lsu_req_valid[0] = 1'b1;
        tick(1);
        lsu_req_valid = 2'b00;
        wait_resp(0);

        // Owner stalls resp_ready for 10 cycles while LSU is requesting.
        mem_rdata = 32'h55AA_55AA;
        ifu_resp_ready[0] = 1'b0;
        ifu_addr = 32'h8000_0080;
        push_exp(0, 1'b0, ifu_addr, 1'b0, 32'h0, 4'h0, mem_rdata, 1'b0);
        ifu_req_valid[0] = 1'b1;
        tick(1);
        ifu_req_valid = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (ifu_resp_valid[0]) seen = 1'b1;
            else tick(1);
        end
        if (!seen) fail("t5_resp_wait");
        lsu_addr = 32'h8000_4000; lsu_wen = 1'b0;
        push_exp(0, 1'b1, lsu_addr, 1'b0, 32'h0, 4'h0, mem_rdata, 1'b0);
        lsu_req_valid[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("t5_hold%0d", c),
                {ifu_resp_valid[0], ifu_rdata[0], ifu_resp_err[0], lsu_req_ready[0]},
                {1'b1, 32'h55AA_55AA, 1'b0, 1'b0});
            tick(1);
        end
        ifu_resp_ready[0] = 1'b1;
        tick(1);
        chk("t5_next_grant", lsu_req_ready[0], 1'b1);
        tick(1);
        lsu_req_valid = 2'b00;
        wait_resp(0);

        // Reset pulse mid-WAIT, then first tie after release goes to IFU.
        silent = 1'b1;
        ifu_addr = 32'h8000_00C0;
        pay_q.push_back('{inst: 0, addr: ifu_addr, wen: 1'b0, wdata: 32'h0, wmask: 4'h0});
        ifu_req_valid[0] = 1'b1;
        tick(1);
        ifu_req_valid = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (mem_resp_ready[0]) seen = 1'b1;
            else tick(1);
        end
        if (!seen) fail("t6_reach_wait");
        #3;
        rst_n = 1'b0;
        silent = 1'b0;
        ifu_req_valid = 2'b11; lsu_req_valid = 2'b11;
        #1;
        chk("t6_req_ready", {ifu_req_ready, lsu_req_ready}, 4'h0);
        chk("t6_mem_side", {mem_req_valid, mem_resp_ready}, 4'h0);
        chk("t6_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 4'h0);
        chk("t6_payload", {mem_addr[0], mem_rdata[0] & 1'b0, ifu_rdata[0], ifu_resp_err[0]}, 66'h0);
        resp_q.delete();
        ifu_req_valid = 2'b00; lsu_req_valid = 2'b00;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        mem_rdata = 32'h7777_0001;
        ifu_addr = 32'h8000_0100;
        lsu_addr = 32'h8000_5000;
        push_exp(0, 1'b0, ifu_addr, 1'b0, 32'h0, 4'h0, mem_rdata, 1'b0);
        ifu_req_valid[0] = 1'b1; lsu_req_valid[0] = 1'b1;
        #1;
        chk("t6_tie_ifu", ifu_req_ready[0], 1'b1);
        chk("t6_tie_lsu", lsu_req_ready[0], 1'b0);
        tick(1);
        ifu_req_valid = 2'b00; lsu_req_valid = 2'b00;
        wait_resp(0);

        tick(2);
        chk("sb_resp_drain", 64'(resp_q.size()), 64'd0);
        chk("sb_pay_drain", 64'(pay_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
